// File: rtl/scazator_pkg.sv
// Shared definitions for the bit-serial subtractor: default width and FSM encoding.
package scazator_pkg;
    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/full_scazator.sv
// One-bit full subtractor cell: d = x - y - bin, bout is the borrow out.
module full_scazator (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/scazator_serial.sv
// Bit-serial unsigned subtractor: one bit per clock, LSB first, result after WIDTH RUN cycles.
module scazator_serial
    import scazator_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);
    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_br;
    logic             r_busy;
    logic             r_done;
    logic             w_d;
    logic             w_bo;
    logic [WIDTH-1:0] w_res_next;

    full_scazator u_cell (
        .x    (r_a[0]),
        .y    (r_b[0]),
        .bin  (r_br),
        .d    (w_d),
        .bout (w_bo)
    );

    assign w_res_next = {w_d, r_res[WIDTH-1:1]};
    assign busy       = r_busy;
    assign done       = r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_res      <= '0;
            r_cnt      <= '0;
            r_br       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_res <= w_res_next;
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_bo;
                    // Counter parks at LAST instead of wrapping when WIDTH is a power of two.
                    if (r_cnt == LAST) begin
                        diff       <= w_res_next;
                        borrow_out <= w_bo;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_scazator_serial.sv
// Scoreboard bench for scazator_serial: driver pushes expected results, negedge monitor checks them.
module tb_scazator_serial;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    int           n_tests = 0;
    int           n_fails = 0;
    int           cyc = 0;
    logic         rst_q = 1'b1;
    bit           mon_en = 1'b0;
    exp_t         q[$];
    logic [W-1:0] hold_d = '0;
    logic         hold_b = 1'b0;

    scazator_serial #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
        n_tests++;
        if (!ok) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: unsigned subtraction modulo 2^W, borrow iff a < b.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input int acc);
        exp_t e;
        int   full;
        full  = int'(ma) - int'(mb);
        e.d   = full[W-1:0];
        e.bo  = (ma < mb);
        e.cyc = acc + W;
        return e;
    endfunction

    // Issue one operation; the DUT must be idle or in DONE when this is called.
    task automatic op(input logic [W-1:0] va, input logic [W-1:0] vb, input bit hold);
        start = 1'b1;
        a     = va;
        b     = vb;
        tick();
        q.push_back(model(va, vb, cyc));
        chk(busy == 1'b1, "busy_after_accept", busy, 1);
        for (int j = 0; j < W; j++) begin
            a     = W'($urandom);
            b     = W'($urandom);
            start = hold ? 1'b1 : 1'($urandom);
            tick();
        end
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        for (int j = 0; j < n; j++) tick();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_q) begin
                hold_d = '0;
                hold_b = 1'b0;
            end
            if (done) begin
                if (q.size() == 0) begin
                    chk(1'b0, "spurious_done", done, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk(cyc == e.cyc, "done_latency", cyc, e.cyc);
                    chk(diff == e.d, "diff", diff, e.d);
                    chk(borrow_out == e.bo, "borrow_out", borrow_out, e.bo);
                    hold_d = e.d;
                    hold_b = e.bo;
                end
            end else begin
                chk(diff == hold_d && borrow_out == hold_b, "result_hold",
                    {diff, borrow_out}, {hold_d, hold_b});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        tick();
        tick();
        chk(busy == 1'b0, "reset_busy", busy, 0);
        chk(done == 1'b0, "reset_done", done, 0);
        chk(diff == '0, "reset_diff", diff, 0);
        chk(borrow_out == 1'b0, "reset_borrow", borrow_out, 0);
        mon_en = 1'b1;
        rst    = 1'b0;

        // Accepted on the first edge after reset release.
        op(8'h05, 8'h03, 1'b0);
        idle(2);
        op(8'h03, 8'h05, 1'b0);
        idle(1);
        op(8'h00, 8'h01, 1'b0);
        op(8'hFF, 8'hFF, 1'b0);
        idle(3);
        op(8'h80, 8'h7F, 1'b0);
        idle(2);
        chk(busy == 1'b0, "idle_busy", busy, 0);

        // Start held high throughout: back-to-back, one result every W+1 cycles.
        for (int i = 0; i < 6; i++) op(W'($urandom), W'($urandom), 1'b1);
        idle(2);

        // Abort in the 4th RUN cycle; no done may follow.
        start = 1'b1;
        a     = 8'h9C;
        b     = 8'h21;
        tick();
        start = 1'b0;
        chk(busy == 1'b1, "abort_busy_run", busy, 1);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk(busy == 1'b0, "abort_busy", busy, 0);
        chk(done == 1'b0, "abort_done", done, 0);
        chk(diff == '0, "abort_diff", diff, 0);
        chk(borrow_out == 1'b0, "abort_borrow", borrow_out, 0);
        rst = 1'b0;
        idle(W + 4);
        op(8'h9C, 8'h21, 1'b0);
        idle(1);

        for (int i = 0; i < 1000; i++) begin
            op(W'($urandom), W'($urandom), 1'($urandom_range(0, 3) == 0));
            idle($urandom_range(0, 2));
        end

        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        chk(q.size() == 0, "drain", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end
endmodule

// File: doc/scazator_serial.md
SCAZATOR_SERIAL -- requirements
Module: scazator_serial

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request to begin one subtraction; sampled on clk rising edge.
REQ-005 SHALL have port: a  input  WIDTH  minuend, unsigned; sampled only when start is accepted.
REQ-006 SHALL have port: b  input  WIDTH  subtrahend, unsigned; sampled only when start is accepted.
REQ-007 SHALL have port: busy  output  1  high while a subtraction is in progress.
REQ-008 SHALL have port: done  output  1  single-cycle pulse marking a valid result.
REQ-009 SHALL have port: diff  output  WIDTH  result (a - b) mod 2^WIDTH.
REQ-010 SHALL have port: borrow_out  output  1  final borrow; 1 iff a < b (unsigned).

Function
REQ-011 SHALL compute bit-serially, LSB first, one bit per clock, through one full-subtractor cell: d = a_i ^ b_i ^ br; bo = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-012 SHALL implement three states: IDLE (busy=0, done=0), RUN (busy=1, done=0), DONE (busy=0, done=1).
REQ-013 SHALL accept start only when busy=0, i.e. in IDLE or DONE; the accepting edge loads a and b into shift registers, clears the borrow flop and bit counter to 0, and enters RUN.
REQ-014 SHALL, on each RUN edge, shift d into the result register MSB, shift both operand registers right by one, load bo into the borrow flop, and increment the counter.
REQ-015 SHALL leave RUN for DONE on the edge where the counter equals WIDTH-1; the counter width is $clog2(WIDTH) bits and it does not wrap during RUN.
REQ-016 SHALL have a fixed latency: start accepted at edge k -> done=1 for exactly the cycle after edge k+WIDTH.
REQ-017 SHALL update diff and borrow_out only on the edge entering DONE, and hold both stable until the next entry into DONE.
REQ-018 SHALL, from DONE, go to RUN if start=1 on that edge (back-to-back operation), else to IDLE.
REQ-019 SHALL ignore start while busy=1, with no effect on operands, counter or result.
REQ-020 SHALL treat a, b and start as don't-care except on the accepting edge; operand changes during RUN do not affect the result.

Reset
REQ-021 SHALL, when rst=1 on a rising edge, force state IDLE, busy=0, done=0, diff=0, borrow_out=0, counter=0, and clear the borrow flop and all shift registers.
REQ-022 SHALL give rst priority over start; reset during RUN aborts the operation, and no done pulse follows.
REQ-023 SHALL accept start on the first edge after rst deasserts.

Structure
REQ-024 SHALL take the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH from shared package scazator_pkg.
REQ-025 SHALL instantiate the combinational 1-bit cell as sub-module full_scazator (inputs x, y, bin; outputs d, bout).
REQ-026 SHALL decode the unused state encoding 2'd3 to IDLE.

Verification (WIDTH=8)
REQ-027 SHALL cover: a=0x05, b=0x03, start pulse -> done 8 cycles after the accepting edge, diff=0x02, borrow_out=0.
REQ-028 SHALL cover: a=0x03, b=0x05 -> diff=0xFE, borrow_out=1; a=0x00, b=0x01 -> diff=0xFF, borrow_out=1.
REQ-029 SHALL cover: a=0xFF, b=0xFF -> diff=0x00, borrow_out=0; a=0x80, b=0x7F -> diff=0x01, borrow_out=0.
REQ-030 SHALL cover: start held high continuously with new operands each DONE cycle -> one done every 9 cycles, each result correct, and start during RUN ignored.
REQ-031 SHALL cover: rst asserted in the 4th RUN cycle -> next cycle busy=0, done=0, diff=0, no done pulse; a following start gives a correct result.
REQ-032 SHALL cover: random a/b, 1000 operations, checked against (a-b) mod 256 and (a<b).
